// File: rtl/alu_logic_cmp_unit_if.sv
// ---------------------------------------------------------------------------
// alu_logic_cmp_unit_if
// Operand/result bundle for the registered ALU logic/compare slice.
//
// Signals
//   in_valid  operands and op are valid this cycle
//   op        2'b00=AND, 2'b01=EQ, 2'b10=GET (a>=b), 2'b11=reserved
//   mode      1=full word, 0=half word (low HALF_W bits)
//   a, b      operands
//   c         registered result word
//   zero      registered zero flag
//   sign      registered sign flag
//   out_valid c/zero/sign were updated by the last clock edge
//
// Modports
//   master  requester side: drives operands, observes results
//   slave   ALU side: observes operands, drives results
// ---------------------------------------------------------------------------
interface alu_logic_cmp_unit_if #(
  parameter int WORD_W = 20
);
  logic              in_valid;
  logic [1:0]        op;
  logic              mode;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic [WORD_W-1:0] c;
  logic              zero;
  logic              sign;
  logic              out_valid;

  modport master (
    output in_valid, op, mode, a, b,
    input  c, zero, sign, out_valid
  );

  modport slave (
    input  in_valid, op, mode, a, b,
    output c, zero, sign, out_valid
  );
endinterface : alu_logic_cmp_unit_if

// File: rtl/alu_logic_cmp_unit.sv
// ---------------------------------------------------------------------------
// alu_logic_cmp_unit
// Registered ALU slice for the 20-bit CPU datapath. Performs bitwise AND,
// equality compare and greater-or-equal compare in full-word (WORD_W bits)
// or half-word (low HALF_W bits) mode, producing a result word plus
// zero/sign flags for the status register and branch logic.
//
// Latency is one cycle with a throughput of one op per cycle and no
// backpressure. When no legal op is accepted, out_valid drops and the
// result/flags hold their previous values.
//
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    alu_logic_cmp_unit_if.slave (operands in, results out)
//
// Configuration
//   ALU_UNSIGNED_CMP_EN  when defined, GET compares a and b as unsigned
//                        W-bit values (sign = borrow of a-b). Otherwise GET
//                        compares as signed two's complement.
// ---------------------------------------------------------------------------
module alu_logic_cmp_unit #(
  parameter int WORD_W = 20,
  parameter int HALF_W = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_logic_cmp_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_EQ   = 2'b01,
    OP_GET  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef struct packed {
    logic [WORD_W-1:0] c;
    logic              zero;
    logic              sign;
  } result_t;

  localparam logic [WORD_W-1:0] HALF_MASK = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};

  // Sign bit of the active width: bit WORD_W-1 in full mode, HALF_W-1 in half.
  function automatic logic top_bit(input logic [WORD_W-1:0] v, input logic full);
    return full ? v[WORD_W-1] : v[HALF_W-1];
  endfunction

  op_e               op_in;
  logic              fire;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] a_m;
  logic [WORD_W-1:0] b_m;
  logic [WORD_W-1:0] diff_raw;
  logic [WORD_W-1:0] diff_w;
  logic [WORD_W-1:0] and_w;
  logic              a_lt_b;
  result_t           res_d;

  assign op_in = op_e'(bus.op);
  assign fire  = bus.in_valid && (op_in != OP_RSVD);

  // Masking the operands up front means every operation below works on
  // WORD_W bits and half mode automatically yields c[WORD_W-1:HALF_W] = 0.
  assign mask = bus.mode ? '1 : HALF_MASK;
  assign a_m  = bus.a & mask;
  assign b_m  = bus.b & mask;

  assign and_w = a_m & b_m;

`ifdef ALU_UNSIGNED_CMP_EN
  logic borrow;

  // Operands are zero-extended, so the carry-out slot is the borrow of an
  // unsigned W-bit subtraction in either mode.
  assign {borrow, diff_raw} = {1'b0, a_m} - {1'b0, b_m};
  assign a_lt_b             = borrow;
`else
  logic msb_a;
  logic msb_b;

  assign diff_raw = a_m - b_m;
  assign msb_a    = top_bit(a_m, bus.mode);
  assign msb_b    = top_bit(b_m, bus.mode);
  // Differing signs: a<b exactly when a is negative (the difference may
  // overflow here, so its sign bit is not trusted). Same signs: the
  // difference cannot overflow and its sign bit is the answer.
  assign a_lt_b   = (msb_a != msb_b) ? msb_a : top_bit(diff_w, bus.mode);
`endif

  // Low bits of the subtraction do not depend on the upper bits, so masking
  // afterwards gives a-b mod 2^W for the half-word case.
  assign diff_w = diff_raw & mask;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    res_d = '0;
    unique case (op_in)
      OP_AND: begin
        res_d.c    = and_w;
        res_d.zero = (and_w == '0);
        res_d.sign = top_bit(and_w, bus.mode);
      end
      OP_EQ: begin
        res_d.c    = a_m ^ b_m;
        res_d.zero = (a_m == b_m);
        res_d.sign = 1'b0;
      end
      OP_GET: begin
        res_d.c    = diff_w;
        res_d.zero = (a_m == b_m);
        res_d.sign = a_lt_b;
      end
      default: res_d = '0;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.c         <= '0;
      bus.zero      <= 1'b0;
      bus.sign      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= fire;
      if (fire) begin
        bus.c    <= res_d.c;
        bus.zero <= res_d.zero;
        bus.sign <= res_d.sign;
      end
    end
  end

endmodule : alu_logic_cmp_unit

// File: tb/tb_alu_logic_cmp_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_logic_cmp_unit
// Self-checking bench for alu_logic_cmp_unit: directed vectors, control
// (reserved op / idle hold), reset priority and randomized back-to-back ops
// compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_logic_cmp_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Expected registered state (holds across idle/reserved cycles).
  logic [19:0] exp_c;
  logic        exp_z;
  logic        exp_s;
  logic        exp_v;

  alu_logic_cmp_unit_if #(.WORD_W(20)) bus ();

  alu_logic_cmp_unit #(.WORD_W(20), .HALF_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic over W bits.
  function automatic void model(input logic [1:0] op, input logic mode,
                                input logic [19:0] a, input logic [19:0] b,
                                output logic [19:0] c, output logic z,
                                output logic s);
    int unsigned w, m, av, bv, r;
    int          sa, sb;
    w  = mode ? 20 : 10;
    m  = 32'd1 << w;
    av = 32'(a) % m;
    bv = 32'(b) % m;
    sa = (av >= m / 2) ? int'(av) - int'(m) : int'(av);
    sb = (bv >= m / 2) ? int'(bv) - int'(m) : int'(bv);
    r  = 0;
    z  = 1'b0;
    s  = 1'b0;
    case (op)
      2'b00: begin r = av & bv; z = (r == 0); s = (r >= m / 2); end
      2'b01: begin r = av ^ bv; z = (av == bv); s = 1'b0; end
      default: begin
        r = (av + m - bv) % m;
        z = (av == bv);
`ifdef ALU_UNSIGNED_CMP_EN
        s = (av < bv);
`else
        s = (sa < sb);
`endif
      end
    endcase
    c = r[19:0];
  endfunction

  // Drive one cycle of stimulus, update the expected state, wait past the edge.
  task automatic apply(input logic v, input logic [1:0] op, input logic mode,
                       input logic [19:0] a, input logic [19:0] b);
    logic [19:0] mc;
    logic        mz, ms;
    bus.in_valid = v;
    bus.op       = op;
    bus.mode     = mode;
    bus.a        = a;
    bus.b        = b;
    if (!rst_n) begin
      exp_c = '0; exp_z = 1'b0; exp_s = 1'b0; exp_v = 1'b0;
    end else if (v && op != 2'b11) begin
      model(op, mode, a, b, mc, mz, ms);
      exp_c = mc; exp_z = mz; exp_s = ms; exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    apply(1'b0, 2'b00, 1'b1, 20'h0, 20'h0);
    apply(1'b0, 2'b00, 1'b1, 20'h0, 20'h0);
    checks++;
    if (bus.c !== 20'h0 || bus.zero !== 1'b0 || bus.sign !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: c=%h zero=%b sign=%b ov=%b required all 0",
               bus.c, bus.zero, bus.sign, bus.out_valid);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        mode;
    logic [19:0] a;
    logic [19:0] b;
    logic [19:0] c;
    logic        z;
    logic        s;
  } vec_t;

`ifdef ALU_UNSIGNED_CMP_EN
  localparam logic S_OVF  = 1'b0;
  localparam logic S_HALF = 1'b0;
`else
  localparam logic S_OVF  = 1'b1;
  localparam logic S_HALF = 1'b1;
`endif

  task automatic test_directed;
    vec_t vecs[9];
    vecs[0] = '{2'b00, 1'b1, 20'hF0F0F, 20'h0FF0F, 20'h00F0F, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 20'hFFC00, 20'hFFFFF, 20'h00000, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 1'b1, 20'h12345, 20'h12345, 20'h00000, 1'b1, 1'b0};
    vecs[3] = '{2'b01, 1'b1, 20'h12345, 20'h12344, 20'h00001, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 1'b1, 20'h80000, 20'h00001, 20'h7FFFF, 1'b0, S_OVF};
    vecs[5] = '{2'b10, 1'b0, 20'hAB3FF, 20'h55001, 20'h003FE, 1'b0, S_HALF};
    vecs[6] = '{2'b10, 1'b0, 20'h00200, 20'h00200, 20'h00000, 1'b1, 1'b0};
    vecs[7] = '{2'b00, 1'b1, 20'h80000, 20'hFFFFF, 20'h80000, 1'b0, 1'b1};
    vecs[8] = '{2'b01, 1'b0, 20'h12345, 20'hFF345, 20'h00000, 1'b1, 1'b0};
    foreach (vecs[i]) begin
      apply(1'b1, vecs[i].op, vecs[i].mode, vecs[i].a, vecs[i].b);
      checks++;
      if (bus.c !== vecs[i].c || bus.zero !== vecs[i].z ||
          bus.sign !== vecs[i].s || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed[%0d]: got c=%h z=%b s=%b ov=%b required c=%h z=%b s=%b ov=1",
                 i, bus.c, bus.zero, bus.sign, bus.out_valid,
                 vecs[i].c, vecs[i].z, vecs[i].s);
      end
    end
  endtask

  task automatic test_control;
    apply(1'b1, 2'b00, 1'b1, 20'hABCDE, 20'hFFFFF);   // c=ABCDE, sign=1
    apply(1'b1, 2'b11, 1'b1, 20'h00000, 20'h00000);   // reserved op
    checks++;
    if (bus.out_valid !== 1'b0 || bus.c !== 20'hABCDE || bus.sign !== 1'b1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reserved_hold: c=%h z=%b s=%b ov=%b required c=abcde z=0 s=1 ov=0",
               bus.c, bus.zero, bus.sign, bus.out_valid);
    end
    apply(1'b0, 2'b01, 1'b0, 20'h11111, 20'h11111);   // idle
    checks++;
    if (bus.out_valid !== 1'b0 || bus.c !== 20'hABCDE || bus.sign !== 1'b1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: c=%h z=%b s=%b ov=%b required c=abcde z=0 s=1 ov=0",
               bus.c, bus.zero, bus.sign, bus.out_valid);
    end
  endtask

  task automatic test_reset_priority;
    apply(1'b1, 2'b00, 1'b1, 20'hFFFFF, 20'hFFFFF);
    rst_n = 1'b0;
    apply(1'b1, 2'b00, 1'b1, 20'hFFFFF, 20'hFFFFF);
    checks++;
    if (bus.c !== 20'h0 || bus.zero !== 1'b0 || bus.sign !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: c=%h z=%b s=%b ov=%b required all 0",
               bus.c, bus.zero, bus.sign, bus.out_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [19:0] ra, rb;
    logic [1:0]  rop;
    logic        rv, rm;
    for (int n = 0; n < 400; n++) begin
      rv  = ($urandom_range(0, 7) != 0);
      rop = 2'($urandom_range(0, 3));
      rm  = 1'($urandom_range(0, 1));
      ra  = 20'($urandom);
      rb  = 20'($urandom);
      // Bias toward equal and boundary operands.
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = rm ? 20'h80000 : {10'($urandom), 10'h200};
        2: rb = rm ? 20'h7FFFF : {10'($urandom), 10'h1FF};
        default: ;
      endcase
      apply(rv, rop, rm, ra, rb);
      checks++;
      if (bus.c !== exp_c || bus.zero !== exp_z || bus.sign !== exp_s || bus.out_valid !== exp_v) begin
        errors++;
        $display("FAIL random[%0d] op=%b mode=%b a=%h b=%h: got c=%h z=%b s=%b ov=%b required c=%h z=%b s=%b ov=%b",
                 n, rop, rm, ra, rb, bus.c, bus.zero, bus.sign, bus.out_valid,
                 exp_c, exp_z, exp_s, exp_v);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.mode     = 1'b1;
    bus.a        = '0;
    bus.b        = '0;
    exp_c = '0; exp_z = 1'b0; exp_s = 1'b0; exp_v = 1'b0;
    test_reset;
    test_directed;
    test_control;
    test_reset_priority;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_logic_cmp_unit
